// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and the framebuffer scheduler state encoding.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_DISPLAY = 480;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vga_fb_scheduler_line_buffer.sv
// One framebuffer row of cells: synchronous write port, asynchronous read port.
module vga_fb_scheduler_line_buffer #(
    parameter int DEPTH  = 80,
    parameter int DATA_W = 4,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] cells_q [DEPTH];

    // Contents intentionally survive reset; stale cells are overwritten by the next fetch.
    always_ff @(posedge clk) begin
        if (we && (widx <= IDX_W'(DEPTH - 1))) begin
            cells_q[widx] <= wdata;
        end
    end

    assign rdata = (ridx <= IDX_W'(DEPTH - 1)) ? cells_q[ridx] : '0;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates a single-port framebuffer RAM between per-row prefetch during
// horizontal blanking and host writes, and scans the prefetched row out as pixels.
module vga_fb_scheduler
    import vga_timing_pkg::*;
#(
    parameter int FB_W   = 80,
    parameter int FB_H   = 60,
    parameter int SCALE  = 8,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              display_en,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pixel_en,
    output logic              fetch_busy
);

    localparam int SHIFT = $clog2(SCALE);
    localparam int IDX_W = $clog2(FB_W);
    localparam int CELLS = FB_W * FB_H;

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] pixel_out_q, pixel_out_d;
    logic              pixel_en_q, pixel_en_d;

    logic [9:0]        next_v_s;
    logic [9:0]        row_s;
    logic [ADDR_W-1:0] row_ext_s;
    logic [ADDR_W-1:0] row_base_s;
    logic              trigger_s;
    logic [IDX_W-1:0]  col_s;
    logic [DATA_W-1:0] lb_rdata_s;

    // Fetch trigger: first line of each SCALE-line band, fired at the start of hblank.
    always_comb begin
        next_v_s   = (v_count >= 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
        trigger_s  = (h_count == 10'(H_DISPLAY)) && (next_v_s < 10'(V_DISPLAY)) &&
                     ((next_v_s & 10'(SCALE - 1)) == 10'd0);
        row_s      = next_v_s >> SHIFT;
        row_ext_s  = ADDR_W'(row_s);
        if (FB_W == 80) begin
            row_base_s = (row_ext_s << 6) + (row_ext_s << 4);
        end else begin
            row_base_s = row_ext_s * ADDR_W'(FB_W);
        end
    end

    // Scheduler next-state and RAM port mux; the host only owns the RAM in IDLE without a trigger.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        host_ready = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        fetch_busy = 1'b0;
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger_s) begin
                        state_d = FETCH;
                        idx_d   = '0;
                        base_d  = row_base_s;
                    end else begin
                        host_ready = 1'b1;
                        if (host_req) begin
                            mem_addr  = host_addr;
                            mem_wdata = host_data;
                            mem_we    = (host_addr < ADDR_W'(CELLS));
                        end else begin
                            mem_we = 1'b0;
                        end
                    end
                end
                FETCH: begin
                    fetch_busy = 1'b1;
                    mem_addr   = base_q + ADDR_W'(idx_q);
                    if (idx_q == IDX_W'(FB_W - 1)) begin
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                WAIT: begin
                    fetch_busy = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Read-data capture pipeline and registered pixel path.
    always_comb begin
        wr_vld_d    = (state_q == FETCH);
        wr_idx_d    = idx_q;
        col_s       = IDX_W'(h_count >> SHIFT);
        pixel_out_d = display_en ? lb_rdata_s : '0;
        pixel_en_d  = display_en;
    end

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            wr_idx_q    <= '0;
            wr_vld_q    <= 1'b0;
            pixel_out_q <= '0;
            pixel_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            wr_idx_q    <= wr_idx_d;
            wr_vld_q    <= wr_vld_d;
            pixel_out_q <= pixel_out_d;
            pixel_en_q  <= pixel_en_d;
        end
    end

    vga_fb_scheduler_line_buffer #(
        .DEPTH  (FB_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (wr_vld_q),
        .widx  (wr_idx_q),
        .wdata (mem_rdata),
        .ridx  (col_s),
        .rdata (lb_rdata_s)
    );

    assign pixel_out = pixel_out_q;
    assign pixel_en  = pixel_en_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: drives sync counters directly, models the RAM,
// and checks fetch windows, host arbitration and scanout against hand-derived values.
module tb_vga_fb_scheduler;
    import vga_timing_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        display_en;
    logic        host_req;
    logic [12:0] host_addr;
    logic [3:0]  host_data;
    logic        host_ready;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [3:0]  pixel_out;
    logic        pixel_en;
    logic        fetch_busy;

    logic [3:0]  ram [0:8191];
    logic        preload;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_line [80];

    typedef struct {
        int v;
        int fetch;
        int base;
    } trig_vec_t;

    typedef struct {
        int addr;
        int data;
        int exp_we;
    } host_vec_t;

    always #5 clk = ~clk;

    vga_fb_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .h_count    (h_count),
        .v_count    (v_count),
        .display_en (display_en),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_ready (host_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pixel_out  (pixel_out),
        .pixel_en   (pixel_en),
        .fetch_busy (fetch_busy)
    );

    // Single-port RAM model: registered read, write at the clock edge; preload cell = row[3:0].
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 8192; a++) ram[a] <= 4'((a / 80) % 16);
            mem_rdata <= 4'd0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (v=%0d h=%0d)", name, act, exp, v_count, h_count);
        end
    endtask

    task automatic set_de();
        display_en = (h_count < 10'd640) && (v_count < 10'd480);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (h_count == 10'(H_TOTAL - 1)) begin
            h_count = 10'd0;
            v_count = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count = h_count + 10'd1;
        end
        set_de();
        #1;
    endtask

    task automatic goto_pos(input int v, input int h);
        @(posedge clk);
        #1;
        v_count = 10'(v);
        h_count = 10'(h);
        set_de();
        #1;
    endtask

    // Called in the trigger cycle (h=640); returns at h=722.
    task automatic check_fetch(input int base);
        chk("trig_ready", host_ready, 0);
        for (int k = 0; k < 80; k++) begin
            cyc();
            chk("fetch_addr", mem_addr, base + k);
            chk("fetch_busy", fetch_busy, 1);
            chk("fetch_we", mem_we, 0);
        end
        cyc();
        chk("wait_busy", fetch_busy, 1);
        cyc();
        chk("done_busy", fetch_busy, 0);
        chk("done_ready", host_ready, 1);
    endtask

    task automatic scan_line(input int line);
        goto_pos(line, 0);
        for (int h = 1; h <= 641; h++) begin
            cyc();
            if (h - 1 < 640) begin
                chk("pix", pixel_out, exp_line[(h - 1) / 8]);
                chk("pix_en", pixel_en, 1);
            end else begin
                chk("pix_blank", pixel_out, 0);
                chk("pix_en_blank", pixel_en, 0);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        trig_vec_t tv [7];
        host_vec_t hv [4];
        int acc;

        tv[0] = '{v: 3,   fetch: 0, base: 0};
        tv[1] = '{v: 8,   fetch: 0, base: 0};
        tv[2] = '{v: 15,  fetch: 1, base: 160};
        tv[3] = '{v: 471, fetch: 1, base: 4720};
        tv[4] = '{v: 479, fetch: 0, base: 0};
        tv[5] = '{v: 523, fetch: 0, base: 0};
        tv[6] = '{v: 0,   fetch: 0, base: 0};

        hv[0] = '{addr: 4800, data: 3,  exp_we: 0};
        hv[1] = '{addr: 8191, data: 3,  exp_we: 0};
        hv[2] = '{addr: 4799, data: 12, exp_we: 1};
        hv[3] = '{addr: 0,    data: 15, exp_we: 1};

        // Reset for 5 cycles at h=0, v=0 with a host request that must be refused.
        reset = 1'b1;
        preload = 1'b1;
        h_count = 10'd0;
        v_count = 10'd0;
        set_de();
        host_req = 1'b1;
        host_addr = 13'd85;
        host_data = 4'd7;
        repeat (5) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_ready", host_ready, 0);
        chk("rst_we", mem_we, 0);
        host_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_pixel_en", pixel_en, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_host_ready", host_ready, 1);

        // Trigger table: which lines launch a fetch and from which base address.
        for (int i = 0; i < 7; i++) begin
            goto_pos(tv[i].v, 639);
            cyc();
            chk("tv_ready", host_ready, tv[i].fetch ? 0 : 1);
            cyc();
            chk("tv_busy", fetch_busy, tv[i].fetch);
            if (tv[i].fetch != 0) chk("tv_base", mem_addr, tv[i].base);
            repeat (81) cyc();
            chk("tv_idle", fetch_busy, 0);
        end

        // Row 1 fetch at v=7 and its scanout on line 8.
        goto_pos(7, 640);
        check_fetch(80);
        for (int c = 0; c < 80; c++) exp_line[c] = 1;
        scan_line(8);

        // Host write table in an idle region.
        goto_pos(100, 100);
        for (int i = 0; i < 4; i++) begin
            host_req = 1'b1;
            host_addr = 13'(hv[i].addr);
            host_data = 4'(hv[i].data);
            #1;
            chk("hv_ready", host_ready, 1);
            chk("hv_we", mem_we, hv[i].exp_we);
            if (hv[i].exp_we != 0) begin
                chk("hv_addr", mem_addr, hv[i].addr);
                chk("hv_wdata", mem_wdata, hv[i].data);
            end
            cyc();
            host_req = 1'b0;
            #1;
        end
        chk("ram_4799", ram[4799], 12);
        chk("ram_0", ram[0], 15);
        chk("ram_4800_kept", ram[4800], 12);
        chk("ram_8191_kept", ram[8191], 6);

        // Host write just before the fetch window, then a request held across it.
        goto_pos(7, 638);
        host_req = 1'b1;
        host_addr = 13'd85;
        host_data = 4'd5;
        #1;
        chk("pre_ready", host_ready, 1);
        chk("pre_we", mem_we, 1);
        chk("pre_addr", mem_addr, 85);
        cyc();
        host_req = 1'b0;
        #1;
        chk("pre_ram", ram[85], 5);
        cyc();
        host_req = 1'b1;
        host_data = 4'd10;
        #1;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (host_ready) begin
                acc = int'(h_count);
                chk("retry_we", mem_we, 1);
                chk("retry_addr", mem_addr, 85);
                chk("retry_wdata", mem_wdata, 10);
            end else begin
                chk("held_no_we", mem_we, 0);
                cyc();
            end
        end
        chk("retry_h", acc, 722);
        cyc();
        host_req = 1'b0;
        #1;
        chk("retry_ram", ram[85], 10);
        // Line buffer still holds the value fetched before the retried write.
        for (int c = 0; c < 80; c++) exp_line[c] = 1;
        exp_line[5] = 5;
        scan_line(8);
        goto_pos(7, 640);
        check_fetch(80);
        exp_line[5] = 10;
        scan_line(8);

        // Reset pulsed mid-fetch, then the next band fetches row 3.
        goto_pos(15, 640);
        chk("mid_trig_ready", host_ready, 0);
        repeat (20) cyc();
        chk("mid_busy", fetch_busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("abort_busy", fetch_busy, 0);
        chk("abort_ready", host_ready, 1);
        cyc();
        chk("abort_addr", mem_addr, 0);
        chk("abort_busy2", fetch_busy, 0);
        goto_pos(23, 640);
        check_fetch(240);

        // Frame wrap: row 0 fetched at v=524, displayed on line 0.
        goto_pos(524, 639);
        cyc();
        check_fetch(0);
        for (int i = 0; i < 200 && !(h_count == 10'd0 && v_count == 10'd0); i++) cyc();
        chk("wrap_v", v_count, 0);
        chk("wrap_h", h_count, 0);
        for (int c = 0; c < 80; c++) exp_line[c] = 0;
        exp_line[0] = 15;
        scan_line(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
